// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-flow opcodes, reset PC default and
// the per-stage metadata carried alongside each fetched instruction.
package pipe_pkg;

  localparam logic [6:0]  JAL              = 7'b1101111;
  localparam logic [6:0]  JALR             = 7'b1100111;
  localparam logic [6:0]  BRANCH           = 7'b1100011;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // IF/ID metadata (PHT index is held separately because its width is a
  // per-instance parameter).
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pred;
    logic        valid;
  } if_id_meta_t;

  // ID/EX metadata; opcode is forced to zero for bubbles.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pred;
    logic [6:0]  opcode;
    logic        valid;
  } id_ex_meta_t;

  function automatic logic is_cf(input logic [6:0] opcode);
    logic cf;
    case (opcode)
      JAL, JALR, BRANCH: cf = 1'b1;
      default:           cf = 1'b0;
    endcase
    return cf;
  endfunction

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // Next count: increment on enable unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_redirect.sv
// Fetch PC sequencer: carries prediction metadata through IF/ID and ID/EX,
// resolves control-flow ops in EX, redirects and flushes on a mispredict.
module fetch_redirect
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = RESET_PC_DEFAULT,
  parameter int          PHT_IDX_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              pc_predicted,
  input  logic [PHT_IDX_WIDTH-1:0] pht_idx,
  input  logic                     stall,
  input  logic [6:0]               id_opcode,
  input  logic                     actual_taken,
  input  logic [31:0]              actual_branch_target,
  output logic [31:0]              pc,
  output logic [31:0]              pc_4,
  output logic [31:0]              if_id_pc,
  output logic [31:0]              if_id_pred,
  output logic                     if_id_valid,
  output logic [31:0]              ID_EX_pc,
  output logic [PHT_IDX_WIDTH-1:0] ID_EX_pht_idx,
  output logic [6:0]               ID_EX_opcode,
  output logic [31:0]              predicted_branch_target,
  output logic                     mispredict,
  output logic [31:0]              cf_count,
  output logic [31:0]              mispredict_count
);

  logic [31:0]              pc_q, pc_d;
  if_id_meta_t              if_id_q, if_id_d;
  id_ex_meta_t              id_ex_q, id_ex_d;
  logic [PHT_IDX_WIDTH-1:0] if_id_idx_q, if_id_idx_d;
  logic [PHT_IDX_WIDTH-1:0] id_ex_idx_q, id_ex_idx_d;
  logic                     ex_cf_s;
  logic [31:0]              actual_next_s;

  assign ex_cf_s       = id_ex_q.valid && is_cf(id_ex_q.opcode);
  assign actual_next_s = actual_taken ? actual_branch_target : (id_ex_q.pc + 32'd4);
  assign mispredict    = ex_cf_s && (actual_next_s != id_ex_q.pred);

  // Next-state selection: mispredict beats stall beats normal advance.
  always_comb begin
    pc_d        = pc_q;
    if_id_d     = if_id_q;
    if_id_idx_d = if_id_idx_q;
    id_ex_d     = id_ex_q;
    id_ex_idx_d = id_ex_idx_q;
    if (mispredict) begin
      pc_d           = actual_next_s;
      if_id_d.valid  = 1'b0;
      id_ex_d.valid  = 1'b0;
      id_ex_d.opcode = 7'd0;
    end else if (stall) begin
      id_ex_d.valid  = 1'b0;
      id_ex_d.opcode = 7'd0;
    end else begin
      pc_d           = pc_predicted;
      if_id_d.pc     = pc_q;
      if_id_d.pred   = pc_predicted;
      if_id_d.valid  = 1'b1;
      if_id_idx_d    = pht_idx;
      id_ex_d.pc     = if_id_q.pc;
      id_ex_d.pred   = if_id_q.pred;
      id_ex_d.valid  = if_id_q.valid;
      id_ex_d.opcode = if_id_q.valid ? id_opcode : 7'd0;
      id_ex_idx_d    = if_id_idx_q;
    end
  end

  // Pipeline registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      if_id_q     <= '0;
      if_id_idx_q <= '0;
      id_ex_q     <= '0;
      id_ex_idx_q <= '0;
    end else begin
      pc_q        <= pc_d;
      if_id_q     <= if_id_d;
      if_id_idx_q <= if_id_idx_d;
      id_ex_q     <= id_ex_d;
      id_ex_idx_q <= id_ex_idx_d;
    end
  end

  sat_counter32 u_cf_count (
    .clk     (clk),
    .rst_n   (reset),
    .inc_i   (ex_cf_s),
    .count_o (cf_count)
  );

  sat_counter32 u_mis_count (
    .clk     (clk),
    .rst_n   (reset),
    .inc_i   (mispredict),
    .count_o (mispredict_count)
  );

  assign pc                      = pc_q;
  assign pc_4                    = pc_q + 32'd4;
  assign if_id_pc                = if_id_q.pc;
  assign if_id_pred              = if_id_q.pred;
  assign if_id_valid             = if_id_q.valid;
  assign ID_EX_pc                = id_ex_q.pc;
  assign ID_EX_pht_idx           = id_ex_idx_q;
  assign ID_EX_opcode            = id_ex_q.opcode;
  assign predicted_branch_target = id_ex_q.pred;

endmodule

// File: tb/tb_fetch_redirect.sv
// Directed bench for fetch_redirect: reset, sequencing, mispredict redirects,
// stall bubbles, counter saturation, pc_4 wrap and asynchronous reset.
module tb_fetch_redirect;
  import pipe_pkg::*;

  localparam logic [6:0] ALU = 7'h13;

  logic        clk;
  logic        reset;
  logic [31:0] pc_predicted;
  logic [4:0]  pht_idx;
  logic        stall;
  logic [6:0]  id_opcode;
  logic        actual_taken;
  logic [31:0] actual_branch_target;
  logic [31:0] pc, pc_4, if_id_pc, if_id_pred, ID_EX_pc, predicted_branch_target;
  logic        if_id_valid, mispredict;
  logic [4:0]  ID_EX_pht_idx;
  logic [6:0]  ID_EX_opcode;
  logic [31:0] cf_count, mispredict_count;

  int checks = 0;
  int errors = 0;

  fetch_redirect #(.RESET_PC(32'h100), .PHT_IDX_WIDTH(5)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .pc_predicted            (pc_predicted),
    .pht_idx                 (pht_idx),
    .stall                   (stall),
    .id_opcode               (id_opcode),
    .actual_taken            (actual_taken),
    .actual_branch_target    (actual_branch_target),
    .pc                      (pc),
    .pc_4                    (pc_4),
    .if_id_pc                (if_id_pc),
    .if_id_pred              (if_id_pred),
    .if_id_valid             (if_id_valid),
    .ID_EX_pc                (ID_EX_pc),
    .ID_EX_pht_idx           (ID_EX_pht_idx),
    .ID_EX_opcode            (ID_EX_opcode),
    .predicted_branch_target (predicted_branch_target),
    .mispredict              (mispredict),
    .cf_count                (cf_count),
    .mispredict_count        (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; pc_predicted = 32'h104; pht_idx = 5'd1; stall = 1'b0;
    id_opcode = ALU; actual_taken = 1'b0; actual_branch_target = 32'h0;
    @(negedge clk);
    // reset state
    check_eq("rst_pc", pc, 32'h100);
    check_eq("rst_pc4", pc_4, 32'h104);
    check_eq("rst_ifv", {31'd0, if_id_valid}, 32'd0);
    check_eq("rst_op", {25'd0, ID_EX_opcode}, 32'd0);
    check_eq("rst_mis", {31'd0, mispredict}, 32'd0);
    check_eq("rst_cf", cf_count, 32'd0);
    check_eq("rst_mcnt", mispredict_count, 32'd0);
    reset = 1'b1;

    // sequential fetch
    tick();
    check_eq("seq1_pc", pc, 32'h104);
    check_eq("seq1_ifpc", if_id_pc, 32'h100);
    check_eq("seq1_op", {25'd0, ID_EX_opcode}, 32'd0);
    pc_predicted = 32'h108;
    tick();
    check_eq("seq2_pc", pc, 32'h108);
    check_eq("seq2_op", {25'd0, ID_EX_opcode}, {25'd0, ALU});
    check_eq("seq2_expc", ID_EX_pc, 32'h100);

    // BRANCH at 0x200 predicted not-taken, actually taken to 0x300
    pc_predicted = 32'h200;
    tick();
    check_eq("b1_pc", pc, 32'h200);
    pc_predicted = 32'h204; pht_idx = 5'd5;
    tick();
    check_eq("b1_ifpred", if_id_pred, 32'h204);
    pc_predicted = 32'h208; id_opcode = BRANCH;
    tick();
    check_eq("b1_expc", ID_EX_pc, 32'h200);
    check_eq("b1_expred", predicted_branch_target, 32'h204);
    check_eq("b1_idx", {27'd0, ID_EX_pht_idx}, 32'd5);
    actual_taken = 1'b1; actual_branch_target = 32'h300;
    #1;
    check_eq("b1_mis", {31'd0, mispredict}, 32'd1);
    tick();
    actual_taken = 1'b0;
    check_eq("b1_redir", pc, 32'h300);
    check_eq("b1_ifv", {31'd0, if_id_valid}, 32'd0);
    check_eq("b1_op", {25'd0, ID_EX_opcode}, 32'd0);
    check_eq("b1_cf", cf_count, 32'd1);
    check_eq("b1_mcnt", mispredict_count, 32'd1);
    check_eq("b1_mis_after", {31'd0, mispredict}, 32'd0);

    // BRANCH at 0x200 predicted taken to 0x300, not taken; stall same cycle
    pc_predicted = 32'h200; id_opcode = 7'd0;
    tick();
    pc_predicted = 32'h300; pht_idx = 5'd9; id_opcode = ALU;
    tick();
    pc_predicted = 32'h304; id_opcode = BRANCH;
    tick();
    check_eq("b2_expc", ID_EX_pc, 32'h200);
    check_eq("b2_idx", {27'd0, ID_EX_pht_idx}, 32'd9);
    actual_taken = 1'b0; stall = 1'b1;
    #1;
    check_eq("b2_mis", {31'd0, mispredict}, 32'd1);
    tick();
    stall = 1'b0;
    check_eq("b2_redir", pc, 32'h204);
    check_eq("b2_ifv", {31'd0, if_id_valid}, 32'd0);
    check_eq("b2_cf", cf_count, 32'd2);
    check_eq("b2_mcnt", mispredict_count, 32'd2);

    // JAL at 0x40 predicted 0x80, correct
    pc_predicted = 32'h40; id_opcode = 7'd0;
    tick();
    pc_predicted = 32'h80; id_opcode = ALU;
    tick();
    pc_predicted = 32'h84; id_opcode = JAL;
    tick();
    check_eq("j_expc", ID_EX_pc, 32'h40);
    actual_taken = 1'b1; actual_branch_target = 32'h80;
    // stall two cycles with ALU op at 0x80 in IF/ID
    stall = 1'b1; id_opcode = ALU; pc_predicted = 32'h88;
    #1;
    check_eq("j_mis", {31'd0, mispredict}, 32'd0);
    tick();
    actual_taken = 1'b0;
    check_eq("j_cf", cf_count, 32'd3);
    check_eq("j_mcnt", mispredict_count, 32'd2);
    check_eq("st1_pc", pc, 32'h84);
    check_eq("st1_ifpc", if_id_pc, 32'h80);
    check_eq("st1_op", {25'd0, ID_EX_opcode}, 32'd0);
    tick();
    check_eq("st2_pc", pc, 32'h84);
    check_eq("st2_ifpc", if_id_pc, 32'h80);
    check_eq("st2_op", {25'd0, ID_EX_opcode}, 32'd0);
    stall = 1'b0;
    tick();
    check_eq("st_rel_pc", pc, 32'h88);
    check_eq("st_rel_op", {25'd0, ID_EX_opcode}, {25'd0, ALU});
    check_eq("st_rel_expc", ID_EX_pc, 32'h80);

    // counter saturation: BRANCH at 0x84 correctly predicted not-taken
    pc_predicted = 32'h8C; id_opcode = BRANCH;
    tick();
    force dut.u_cf_count.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_cf_count.count_q;
    actual_taken = 1'b0;
    #1;
    check_eq("sat_pre", cf_count, 32'hFFFF_FFFF);
    check_eq("sat_mis", {31'd0, mispredict}, 32'd0);
    pc_predicted = 32'hFFFF_FFFC; id_opcode = ALU;
    tick();
    check_eq("sat_cf", cf_count, 32'hFFFF_FFFF);
    check_eq("sat_mcnt", mispredict_count, 32'd2);
    check_eq("wrap_pc4", pc_4, 32'h0);

    // asynchronous reset pulse between edges
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_pc", pc, 32'h100);
    check_eq("arst_ifv", {31'd0, if_id_valid}, 32'd0);
    check_eq("arst_op", {25'd0, ID_EX_opcode}, 32'd0);
    check_eq("arst_cf", cf_count, 32'd0);
    check_eq("arst_mcnt", mispredict_count, 32'd0);
    reset = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
